debounce_sync: RTL and testbench



---
 rtl/debounce_sync.sv | 134 +++++++++++++
 tb/tb_debounce_sync.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debounce_sync                                              |
// | Purpose  : Synchronises a raw asynchronous 1-bit input into the clk   |
// |            domain, rejects glitches with a confirm counter and a      |
// |            4-state FSM, and produces a clean level plus one-cycle     |
// |            rise/fall pulses.                                          |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module debounce_sync #(
  parameter int SYNC_STAGES    = 2,
  parameter int CONFIRM_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   q_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  // Synchroniser chain: din enters at bit 0 and shifts toward the MSB.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Only the last synchroniser stage is allowed to reach the filter.
  assign s_sync = sync_q[SYNC_STAGES-1];

  // Confirm FSM: a new level commits only after CONFIRM_CYCLES+1 consecutive
  // samples; all outputs are registered so nothing from din is combinational.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Pulses default low so they last exactly one cycle after a commit.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE_LOW: begin
          if (s_sync) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s_sync) begin
            // Excursion too short: drop back without touching q.
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CONFIRM_C) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            q_q     <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s_sync) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s_sync) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CONFIRM_C) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_debounce_sync                                           |
// | Purpose  : Directed bench for debounce_sync; rise/fall pulses are     |
// |            matched against a queue of expected events by a monitor.   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_debounce_sync;

  logic clk;
  logic rstb;
  logic din;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  int checks;
  int errors;
  int edge_n;

  typedef struct {
    bit is_rise;
    int at_edge;
  } ev_t;

  ev_t exp_q[$];

  debounce_sync #(
    .SYNC_STAGES   (2),
    .CONFIRM_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .din (din),
    .q   (q),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after the k-th posedge, edge_n == k.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_rise, input int at_edge);
    ev_t e;
    e.is_rise = is_rise;
    e.at_edge = at_edge;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse seen must match the head of the expected queue.
  always @(negedge clk) begin
    if (rise && fall) begin
      check("rise_and_fall_together", 1, 0);
    end
    if (rise || fall) begin
      if (exp_q.size() == 0) begin
        check(rise ? "unexpected_rise" : "unexpected_fall", 1, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_kind_is_rise", int'(rise), int'(e.is_rise));
        check("pulse_edge", edge_n, e.at_edge);
      end
    end
  end

  initial begin
    int base;
    checks = 0;
    errors = 0;
    edge_n = 0;
    din    = 1'b0;
    rstb   = 1'b0;

    // Reset state
    repeat (3) step();
    check("reset_q", int'(q), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    check("reset_busy", int'(busy), 0);

    // Clean rise: release reset and raise din before E1
    rstb = 1'b1;
    din  = 1'b1;
    base = edge_n;
    push(1'b1, base + 7);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("rise_busy", int'(busy), int'(k >= 3 && k <= 6));
      check("rise_q", int'(q), int'(k >= 7));
      if (k >= 7) check("rise_pulse", int'(rise), int'(k == 7));
    end

    // Async reset between edges from IDLE_HIGH
    #2;
    rstb = 1'b0;
    #1;
    check("async_q", int'(q), 0);
    check("async_rise", int'(rise), 0);
    check("async_fall", int'(fall), 0);
    check("async_busy", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("held_q", int'(q), 0);
      check("held_busy", int'(busy), 0);
    end
    din  = 1'b0;
    rstb = 1'b1;
    repeat (4) step();

    // Glitch: s high on exactly 4 edges is rejected
    base = edge_n;
    din  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) din = 1'b0;
      check("glitch4_busy", int'(busy), int'(k >= 3 && k <= 6));
      check("glitch4_q", int'(q), 0);
    end

    // 5 edges high is accepted, then the low level is accepted too
    base = edge_n;
    din  = 1'b1;
    push(1'b1, base + 7);
    push(1'b0, base + 12);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 5) din = 1'b0;
      check("glitch5_q", int'(q), int'(k >= 7 && k < 12));
    end

    // Chatter: toggle every 2 cycles for 40 cycles, then settle high
    base = edge_n;
    for (int i = 0; i < 40; i++) begin
      din = ((i / 2) % 2) == 0;
      step();
      check("chatter_q", int'(q), 0);
    end
    din = 1'b1;
    push(1'b1, base + 47);
    for (int k = 41; k <= 50; k++) begin
      step();
      check("chatter_settle_q", int'(q), int'(k >= 47));
    end

    // Clean fall from IDLE_HIGH
    base = edge_n;
    din  = 1'b0;
    push(1'b0, base + 7);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("fall_q", int'(q), int'(k < 7));
      check("fall_rise_low", int'(rise), 0);
      if (k >= 7) check("fall_pulse", int'(fall), int'(k == 7));
    end
    repeat (3) step();

    // Reset mid-confirm, then full latency re-counted after release
    din = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    check("midconf_busy", int'(busy), 1);
    rstb = 1'b0;
    #1;
    check("midconf_busy_reset", int'(busy), 0);
    check("midconf_q_reset", int'(q), 0);
    step();
    step();
    rstb = 1'b1;
    base = edge_n;
    push(1'b1, base + 7);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("post_reset_q", int'(q), int'(k >= 7));
      check("post_reset_busy", int'(busy), int'(k >= 3 && k <= 6));
    end

    repeat (3) step();
    check("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
